// File: rtl/tv_pkg.sv
// Shared types and constants for the 3-input gate response checker.
package tv_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSync  = 2'd1,
    StCheck = 2'd2,
    StDone  = 2'd3
  } tv_state_e;

  // Truth tables: bit k is the gate output for vector k = {in2,in1,in0}.
  localparam logic [7:0] TruthAnd3  = 8'h80;
  localparam logic [7:0] TruthNand3 = 8'h7F;
  localparam logic [7:0] TruthOr3   = 8'hFE;
  localparam logic [7:0] TruthNor3  = 8'h01;
  localparam logic [7:0] TruthXor3  = 8'h96;
  localparam logic [7:0] TruthXnor3 = 8'h69;

  localparam int unsigned SyncTimeout = 16;

endpackage

// File: rtl/tv_sat_cnt.sv
// Saturating up-counter with synchronous clear and increment enable.
module tv_sat_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {Width{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tv_checker.sv
// Checks gate responses against a truth table and verifies 0..7 vector order
// over a configurable number of sweeps.
module tv_checker
  import tv_pkg::*;
#(
  parameter logic [7:0]  TRUTH    = TruthAnd3,
  parameter int unsigned N_SWEEPS = 1,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0,
  input  logic             in1,
  input  logic             in2,
  input  logic             dut_out,
  input  logic             start,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             seq_err,
  output logic [2:0]       first_err_vec,
  output logic             first_err_valid
);

  localparam logic [6:0] NumSamples = 7'(8 * N_SWEEPS);
  localparam logic [3:0] TmoLast    = 4'(SyncTimeout - 1);

  tv_state_e  state_q;
  logic [2:0] exp_q;
  logic [6:0] cnt_q;
  logic [3:0] tmo_q;

  logic [2:0] vec;
  logic       sample_en;
  logic       mismatch;
  logic       seq_err_d;
  logic       err_free_d;
  logic       last_sample;

  always_comb begin
    vec = {in2, in1, in0};
    // SYNC samples only the aligning vector 0; CHECK samples every edge.
    sample_en   = !start && (((state_q == StSync) && (vec == 3'd0)) || (state_q == StCheck));
    mismatch    = sample_en && (dut_out != TRUTH[vec]);
    seq_err_d   = seq_err | (sample_en && (vec != exp_q));
    err_free_d  = !(first_err_valid | mismatch) && !seq_err_d;
    // cnt_q is 0 in SYNC, so a single-sample run also ends here.
    last_sample = (cnt_q + 7'd1) == NumSamples;
  end

  tv_sat_cnt #(
    .Width(CNT_W)
  ) u_err_cnt (
    .clk(clk),
    .rst(rst),
    .clr(start),
    .inc(mismatch),
    .cnt(err_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      exp_q           <= 3'd0;
      cnt_q           <= 7'd0;
      tmo_q           <= 4'd0;
      done            <= 1'b0;
      pass            <= 1'b0;
      seq_err         <= 1'b0;
      first_err_vec   <= 3'd0;
      first_err_valid <= 1'b0;
    end else if (start) begin
      state_q         <= StSync;
      exp_q           <= 3'd0;
      cnt_q           <= 7'd0;
      tmo_q           <= 4'd0;
      done            <= 1'b0;
      pass            <= 1'b0;
      seq_err         <= 1'b0;
      first_err_vec   <= 3'd0;
      first_err_valid <= 1'b0;
    end else begin
      if (mismatch && !first_err_valid) begin
        first_err_vec   <= vec;
        first_err_valid <= 1'b1;
      end
      case (state_q)
        StSync, StCheck: begin
          if (sample_en) begin
            exp_q   <= exp_q + 3'd1;
            cnt_q   <= cnt_q + 7'd1;
            seq_err <= seq_err_d;
            if (last_sample) begin
              state_q <= StDone;
              done    <= 1'b1;
              pass    <= err_free_d;
            end else begin
              state_q <= StCheck;
            end
          end else if (tmo_q == TmoLast) begin
            seq_err <= 1'b1;
            state_q <= StDone;
            done    <= 1'b1;
            pass    <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tv_checker.sv
// Self-checking bench for tv_checker: directed table, hand sequences and
// randomized streams scored against a sweep-level reference model.
module tb_tv_checker;

  typedef struct {
    int consumed;
    int err;
    bit seq;
    bit fvalid;
    int fv;
    bit pass;
  } results_t;

  typedef struct {
    logic [2:0] start_v;
    logic [7:0] gate_tt;
    results_t   exp;
  } vec_t;

  localparam int StreamLen = 44;

  logic       clk = 1'b0;
  logic       rst;
  logic       in0, in1, in2;
  logic       dut_out_a, dut_out_b;
  logic       start;
  logic       done_a, pass_a, seq_err_a, fev_valid_a;
  logic [3:0] err_cnt_a;
  logic [2:0] fev_a;
  logic       done_b, pass_b, seq_err_b, fev_valid_b;
  logic [1:0] err_cnt_b;
  logic [2:0] fev_b;

  logic [2:0] sv [StreamLen];
  bit         oa [StreamLen];
  bit         ob [StreamLen];
  int         done_at_a, done_at_b;
  int         n_chk = 0;
  int         n_fail = 0;
  vec_t       tbl [6];

  always #5 clk = ~clk;

  tv_checker #(
    .TRUTH(8'h80),
    .N_SWEEPS(1),
    .CNT_W(4)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .in0(in0),
    .in1(in1),
    .in2(in2),
    .dut_out(dut_out_a),
    .start(start),
    .done(done_a),
    .pass(pass_a),
    .err_cnt(err_cnt_a),
    .seq_err(seq_err_a),
    .first_err_vec(fev_a),
    .first_err_valid(fev_valid_a)
  );

  tv_checker #(
    .TRUTH(8'h96),
    .N_SWEEPS(3),
    .CNT_W(2)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .in0(in0),
    .in1(in1),
    .in2(in2),
    .dut_out(dut_out_b),
    .start(start),
    .done(done_b),
    .pass(pass_b),
    .err_cnt(err_cnt_b),
    .seq_err(seq_err_b),
    .first_err_vec(fev_b),
    .first_err_valid(fev_valid_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input logic [2:0] v);
    {in2, in1, in0} = v;
  endtask

  // Free-running generator starting at start_v, both gates ideal unless inverted.
  task automatic fill_free(input logic [2:0] start_v, input logic [7:0] tt_a,
                           input logic [7:0] tt_b, input bit inv_b);
    for (int k = 0; k < StreamLen; k++) begin
      sv[k] = 3'(int'(start_v) + k);
      oa[k] = tt_a[sv[k]];
      ob[k] = tt_b[sv[k]] ^ inv_b;
    end
  endtask

  // Pulse start, then apply len samples, noting the sample after which done rose.
  task automatic run_stream(input int len);
    @(negedge clk);
    start = 1'b1;
    set_vec(3'd6);
    dut_out_a = 1'b0;
    dut_out_b = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("clear_on_start", {29'd0, done_a, fev_valid_a, seq_err_a} | int'(err_cnt_a), 0);
    done_at_a = -1;
    done_at_b = -1;
    for (int k = 0; k < len; k++) begin
      set_vec(sv[k]);
      dut_out_a = oa[k];
      dut_out_b = ob[k];
      @(negedge clk);
      if (done_a && done_at_a < 0) done_at_a = k + 1;
      if (done_b && done_at_b < 0) done_at_b = k + 1;
    end
  endtask

  // Reference: locate the first vector 0 within the timeout window, then score
  // the next 8*nsw samples against truth table and the 0..7 cycle.
  function automatic results_t model(input logic [7:0] tt, input int nsw, input int cntw,
                                     input bit use_b);
    results_t r;
    int sync = -1;
    int errs = 0;
    int maxc = (1 << cntw) - 1;
    r.consumed = 0;
    r.seq = 0;
    r.fvalid = 0;
    r.fv = 0;
    for (int i = 0; i < 16; i++) if (sync < 0 && sv[i] == 3'd0) sync = i;
    if (sync < 0) begin
      r.consumed = 16;
      r.seq = 1;
    end else begin
      r.consumed = sync + 8 * nsw;
      for (int j = 0; j < 8 * nsw; j++) begin
        logic [2:0] v;
        bit o;
        v = sv[sync + j];
        o = use_b ? ob[sync + j] : oa[sync + j];
        if (int'(v) != j % 8) r.seq = 1;
        if (o != tt[v]) begin
          errs++;
          if (!r.fvalid) begin
            r.fvalid = 1;
            r.fv = int'(v);
          end
        end
      end
    end
    r.err = (errs > maxc) ? maxc : errs;
    r.pass = (errs == 0) && !r.seq;
    return r;
  endfunction

  task automatic compare(input string tag, input int done_at, input bit done, input bit pass,
                         input int err, input bit seq, input int fv, input bit fvalid,
                         input results_t e);
    chk({tag, ".done_at"}, done_at, e.consumed);
    chk({tag, ".done"}, int'(done), 1);
    chk({tag, ".err_cnt"}, err, e.err);
    chk({tag, ".seq_err"}, int'(seq), int'(e.seq));
    chk({tag, ".first_err_valid"}, int'(fvalid), int'(e.fvalid));
    chk({tag, ".first_err_vec"}, fv, e.fv);
    chk({tag, ".pass"}, int'(pass), int'(e.pass));
  endtask

  task automatic compare_a(input string tag, input results_t e);
    compare(tag, done_at_a, done_a, pass_a, int'(err_cnt_a), seq_err_a, int'(fev_a),
            fev_valid_a, e);
  endtask

  task automatic compare_b(input string tag, input results_t e);
    compare(tag, done_at_b, done_b, pass_b, int'(err_cnt_b), seq_err_b, int'(fev_b),
            fev_valid_b, e);
  endtask

  initial begin
    tbl[0] = '{3'd0, 8'h80, '{8, 0, 0, 0, 0, 1}};   // correct AND3
    tbl[1] = '{3'd0, 8'hFE, '{8, 6, 0, 1, 1, 0}};   // OR in place of AND
    tbl[2] = '{3'd5, 8'h80, '{11, 0, 0, 0, 0, 1}};  // sync after 5,6,7
    tbl[3] = '{3'd1, 8'h7F, '{15, 8, 0, 1, 0, 0}};  // NAND, late sync
    tbl[4] = '{3'd0, 8'h96, '{8, 3, 0, 1, 1, 0}};   // XOR
    tbl[5] = '{3'd3, 8'h01, '{13, 2, 0, 1, 0, 0}};  // NOR

    rst = 1'b0;
    start = 1'b0;
    set_vec(3'd0);
    dut_out_a = 1'b0;
    dut_out_b = 1'b0;
    #3;
    chk("reset.done", int'(done_a), 0);
    chk("reset.pass", int'(pass_a), 0);
    chk("reset.err_cnt", int'(err_cnt_a), 0);
    chk("reset.flags", int'({seq_err_a, fev_valid_a, fev_a}), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      fill_free(tbl[i].start_v, tbl[i].gate_tt, 8'h96, 1'b0);
      run_stream(StreamLen);
      compare_a($sformatf("table%0d", i), tbl[i].exp);
    end

    // Generator stuck at vector 3: both checkers time out after 16 edges.
    for (int k = 0; k < StreamLen; k++) begin
      sv[k] = 3'd3;
      oa[k] = 1'b0;
      ob[k] = 1'b0;
    end
    run_stream(StreamLen);
    compare_a("stuck_a", '{16, 0, 1, 0, 0, 0});
    compare_b("stuck_b", '{16, 0, 1, 0, 0, 0});

    // Vector 3 skipped, gate outputs correct for what is applied.
    fill_free(3'd0, 8'h80, 8'h96, 1'b0);
    for (int k = 3; k < StreamLen; k++) begin
      sv[k] = 3'(k + 1);
      oa[k] = sv[k] == 3'd7;
    end
    run_stream(StreamLen);
    compare_a("skip", '{8, 0, 1, 0, 0, 0});

    // Inverted gate over three sweeps saturates the 2-bit counter.
    fill_free(3'd0, 8'h80, 8'h96, 1'b1);
    run_stream(StreamLen);
    compare_b("saturate", '{24, 3, 0, 1, 0, 0});

    for (int it = 0; it < 20; it++) begin
      logic [2:0] v;
      v = 3'($urandom_range(0, 7));
      for (int k = 0; k < StreamLen; k++) begin
        if (k > 0) v = sv[k-1] + 3'd1;
        if ($urandom_range(0, 11) == 0) v = 3'($urandom_range(0, 7));
        sv[k] = v;
        oa[k] = (8'h80 >> v) & 8'h01 ? 1'b1 : 1'b0;
        ob[k] = (8'h96 >> v) & 8'h01 ? 1'b1 : 1'b0;
        if ($urandom_range(0, 9) == 0) oa[k] = !oa[k];
        if ($urandom_range(0, 9) == 0) ob[k] = !ob[k];
      end
      run_stream(StreamLen);
      compare_a($sformatf("rand%0d_a", it), model(8'h80, 1, 4, 1'b0));
      compare_b($sformatf("rand%0d_b", it), model(8'h96, 3, 2, 1'b1));
    end

    // Asynchronous reset mid-CHECK, away from any clock edge.
    fill_free(3'd0, 8'hFE, 8'h96, 1'b0);
    run_stream(4);
    chk("pre_reset.err_cnt", int'(err_cnt_a), 3);
    chk("pre_reset.first_err_vec", int'(fev_a), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset.err_cnt", int'(err_cnt_a), 0);
    chk("async_reset.flags", int'({done_a, pass_a, seq_err_a, fev_valid_a, fev_a}), 0);
    @(negedge clk);
    rst = 1'b1;
    // Mismatching vector 0 must be ignored while idle.
    set_vec(3'd0);
    dut_out_a = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle.err_cnt", int'(err_cnt_a), 0);
    chk("idle.done", int'(done_a), 0);

    // Failing run to DONE, then restart from DONE with a correct gate.
    fill_free(3'd0, 8'hFE, 8'h96, 1'b0);
    run_stream(StreamLen);
    compare_a("before_restart", '{8, 6, 0, 1, 1, 0});
    fill_free(3'd0, 8'h80, 8'h96, 1'b0);
    run_stream(StreamLen);
    compare_a("restart", '{8, 0, 0, 0, 0, 1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tv_checker.md
# tv_checker

Response checker for the 3-input logic-gate test bench: the receiving end of the 8-state test-vector sequence. It samples the applied vector (in2,in1,in0) and the gate-under-test output on every rising clock edge, compares each output against a parameterised truth table, and verifies that vectors arrive in the 0→7 wrap-around order. After a programmable number of full sweeps it reports pass/fail, a saturating error count and the first failing vector. It sits beside the vector generator and the gate under test, on the same clock and reset.

## Interface
- `TRUTH`, 8'h80 — expected output per vector index; bit k = expected `dut_out` for vector k, where k = {in2,in1,in0}. The default is AND3.
- `N_SWEEPS`, 1 — number of full 8-vector sweeps to check, 1..15.
- `CNT_W`, 4 — width of `err_cnt`.

- `clk` input 1 — clock; all state changes on the rising edge.
- `rst` input 1 — asynchronous, active-low reset.
- `in0`, `in1`, `in2` input 1 each — applied vector; `in2` is the MSB.
- `dut_out` input 1 — gate-under-test output. It is combinational from the vector and is stable at the sampling edge.
- `start` input 1 — single-cycle pulse that arms a new check run.
- `done` output 1 — registered; high while in DONE.
- `pass` output 1 — registered; valid only when `done`=1.
- `err_cnt` output CNT_W — count of output mismatches; saturates at all-ones.
- `seq_err` output 1 — sticky flag: out-of-order vector or sync timeout.
- `first_err_vec` output 3 — vector index of the first output mismatch.
- `first_err_valid` output 1 — high once `first_err_vec` has been captured.

## Operation
- State machine states: IDLE, SYNC, CHECK, DONE.
- **Reset** (`rst`=0, any time, including mid-run):
  - State goes to IDLE.
  - All outputs, the sample counter, the expected index and the timeout counter clear to 0.
- **IDLE**:
  - `start`=1 → SYNC; counters and flags clear on the same edge.
- **SYNC**:
  - Waits for vector 3'b000.
  - On the edge where vec==0, that sample is checked. Then expected index ← 1, sample count ← 1, and the state goes to CHECK. If N_SWEEPS×8 == 1 the state would go straight to DONE instead; this case is unreachable for N_SWEEPS ≥ 1.
  - Timeout: if 16 consecutive edges pass in SYNC without vec==0, set `seq_err`=1 and go to DONE.
- **CHECK**: on every edge:
  - Mismatch check: if `dut_out` ≠ TRUTH[vec], increment `err_cnt` (held at max once saturated). On the first mismatch of the run, capture vec into `first_err_vec` and set `first_err_valid`.
  - Order check: if vec ≠ expected index, set `seq_err`. The expected index then advances from the expected value, not from the received vector: (exp+1) mod 8, so 7 wraps to 0.
  - Sample count increments. On the edge that checks sample number 8×N_SWEEPS, go to DONE.
- **DONE**:
  - `done`=1 and `pass` = (`err_cnt`==0 && !`seq_err`).
  - Outputs hold until reset or `start`.
- **`start` outside IDLE**:
  - In DONE, `start`=1 → SYNC with a full clear.
  - In SYNC or CHECK, `start` restarts the run: full clear, then SYNC.
- **Simultaneous events**: the mismatch check and the order check can both fire on one edge; both are recorded. A mismatch on the final sample is counted before entering DONE.

## Timing
- Checking latency: a sample taken at edge t is reflected in `err_cnt`, `seq_err` and `first_err_*` after edge t.
- `done` rises after the edge that takes the final sample. The minimum run is 1 + 8×N_SWEEPS edges from the `start` edge, reached when vector 0 is present immediately.
- `done`, `pass` and all status outputs are registered (glitch-free).
- The sample counter is 7 bits; 8×15 = 120 does not overflow.

## Structure
- Shared package `tv_pkg` holds:
  - State encodings (IDLE=0, SYNC=1, CHECK=2, DONE=3).
  - Truth-table constants: AND3=8'h80, NAND3=8'h7F, OR3=8'hFE, NOR3=8'h01, XOR3=8'h96, XNOR3=8'h69.
  - The sync-timeout constant, 16.
- One sub-module, `tv_sat_cnt`: a parameterised saturating counter with synchronous clear and increment enable, used for `err_cnt`.

## Test plan
- **Correct AND3**: TRUTH=8'h80, gate=AND, generator free-running, `start` pulsed → `done`=1 after 9 edges, `pass`=1, `err_cnt`=0, `first_err_valid`=0.
- **Wrong gate**: TRUTH=8'h80 but DUT is OR → 6 mismatches (vectors 1–6), `err_cnt`=6, `first_err_vec`=3'd1, `pass`=0.
- **Stuck vector**: generator held at vector 3 → SYNC times out after 16 edges, `seq_err`=1, `done`=1, `pass`=0.
- **Skipped vector**: sequence 0,1,2,4,5,6,7,0 → `seq_err`=1 and `err_cnt`=0 with a correct DUT, `pass`=0.
- **Saturation**: CNT_W=2, N_SWEEPS=3, DUT output inverted → `err_cnt`=3 (saturated) after 24 samples, `first_err_vec`=0.
- **Reset and restart**: assert `rst` low mid-CHECK → all outputs 0 immediately (asynchronous), state IDLE. Then `start` in DONE → counters clear and a new run completes normally.
